// File: rtl/perceptron_eval_if.sv
// Sample/result handshake bundle for perceptron_eval.
// The slave modport is the evaluator; master is the producer/consumer side.
interface perceptron_eval_if;
  logic               sample_valid;
  logic               sample_ready;
  logic [15:0]        sample;
  logic               result_valid;
  logic               result_ready;
  logic signed [13:0] y_out;
  logic [1:0]         pred;
  logic               err;

  modport slave (
    input  sample_valid,
    input  sample,
    input  result_ready,
    output sample_ready,
    output result_valid,
    output y_out,
    output pred,
    output err
  );

  modport master (
    output sample_valid,
    output sample,
    output result_ready,
    input  sample_ready,
    input  result_valid,
    input  y_out,
    input  pred,
    input  err
  );
endinterface

// File: rtl/perceptron_eval.sv
// Perceptron inference: y = w1*x1 + w2*x2 + b over one shared multiplier,
// sign classification against the target, and saturating accuracy counters.
module perceptron_eval #(
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld_w,
  input  logic signed [13:0] w1_in,
  input  logic signed [13:0] w2_in,
  input  logic signed [13:0] b_in,
  input  logic               clr_stats,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  perceptron_eval_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StMul1, StMul2, StResp} state_e;

  state_e             state_q;
  logic signed [13:0] w1_q, w2_q, b_q;
  logic signed [13:0] op_w1_q, op_w2_q;
  logic signed [6:0]  x1_q, x2_q;
  logic [1:0]         t_q;
  logic signed [17:0] acc_q;
  logic signed [13:0] y_q;
  logic [1:0]         pred_q;
  logic               err_q;
  logic               sample_ready_q;
  logic               result_valid_q;
  logic [CNT_W-1:0]   sample_cnt_q, err_cnt_q;

  logic signed [20:0] mul_w, mul_x, prod, prod_shr;
  logic signed [17:0] acc_sum;
  logic signed [13:0] y_sat;
  logic               hs;

  // Shared multiplier: w1*x1 in MUL1, w2*x2 otherwise (only MUL2 consumes it).
  always_comb begin
    mul_w = '0;
    mul_x = '0;
    if (state_q == StMul1) begin
      mul_w = {{7{op_w1_q[13]}}, op_w1_q};
      mul_x = {{14{x1_q[6]}}, x1_q};
    end else begin
      mul_w = {{7{op_w2_q[13]}}, op_w2_q};
      mul_x = {{14{x2_q[6]}}, x2_q};
    end
    prod     = mul_w * mul_x;
    prod_shr = prod >>> 4;
    acc_sum  = acc_q + $signed(prod_shr[17:0]);
  end

  always_comb begin
    y_sat = '0;
    if (acc_sum > 18'sd8191) begin
      y_sat = 14'sd8191;
    end else if (acc_sum < -18'sd8192) begin
      y_sat = -14'sd8192;
    end else begin
      y_sat = $signed(acc_sum[13:0]);
    end
  end

  assign hs = (state_q == StResp) && bus.result_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      w1_q           <= '0;
      w2_q           <= '0;
      b_q            <= '0;
      op_w1_q        <= '0;
      op_w2_q        <= '0;
      x1_q           <= '0;
      x2_q           <= '0;
      t_q            <= '0;
      acc_q          <= '0;
      y_q            <= '0;
      pred_q         <= 2'b01;
      err_q          <= 1'b0;
      sample_ready_q <= 1'b1;
      result_valid_q <= 1'b0;
      sample_cnt_q   <= '0;
      err_cnt_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.sample_valid && sample_ready_q) begin
            x1_q           <= $signed(bus.sample[15:9]);
            x2_q           <= $signed(bus.sample[8:2]);
            t_q            <= bus.sample[1:0];
            // Snapshot weights so a coincident ld_w only affects later samples.
            op_w1_q        <= w1_q;
            op_w2_q        <= w2_q;
            acc_q          <= {{4{b_q[13]}}, b_q};
            sample_ready_q <= 1'b0;
            state_q        <= StMul1;
          end
          if (ld_w) begin
            w1_q <= w1_in;
            w2_q <= w2_in;
            b_q  <= b_in;
          end
        end
        StMul1: begin
          acc_q   <= acc_sum;
          state_q <= StMul2;
        end
        StMul2: begin
          acc_q          <= acc_sum;
          y_q            <= y_sat;
          pred_q         <= acc_sum[17] ? 2'b11 : 2'b01;
          err_q          <= acc_sum[17] != t_q[1];
          result_valid_q <= 1'b1;
          state_q        <= StResp;
        end
        StResp: begin
          if (hs) begin
            result_valid_q <= 1'b0;
            sample_ready_q <= 1'b1;
            state_q        <= StIdle;
            if (sample_cnt_q != '1) begin
              sample_cnt_q <= sample_cnt_q + CNT_W'(1);
            end
            if (err_q && (err_cnt_q != '1)) begin
              err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
      // Clear overrides any coincident handshake count.
      if (clr_stats) begin
        sample_cnt_q <= '0;
        err_cnt_q    <= '0;
      end
    end
  end

  assign bus.sample_ready = sample_ready_q;
  assign bus.result_valid = result_valid_q;
  assign bus.y_out        = y_q;
  assign bus.pred         = pred_q;
  assign bus.err          = err_q;
  assign sample_cnt       = sample_cnt_q;
  assign err_cnt          = err_cnt_q;

endmodule

// File: tb/tb_perceptron_eval.sv
// Bench for perceptron_eval: per-cycle check against a behavioural model plus
// directed samples with hand-computed results.
module tb_perceptron_eval;
  localparam int unsigned CNT_W = 8;
  localparam int MAXC = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ld_w = 1'b0;
  logic signed [13:0] w1_in = '0, w2_in = '0, b_in = '0;
  logic clr_stats = 1'b0;
  logic [CNT_W-1:0] sample_cnt, err_cnt;

  perceptron_eval_if bus ();

  perceptron_eval #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .ld_w       (ld_w),
    .w1_in      (w1_in),
    .w2_in      (w2_in),
    .b_in       (b_in),
    .clr_stats  (clr_stats),
    .sample_cnt (sample_cnt),
    .err_cnt    (err_cnt),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  int m_w1, m_w2, m_b;
  int m_sc, m_ec;
  bit m_busy, m_rv;
  int m_age;
  int m_y, m_p, m_e;

  function automatic void eval(input int w1, input int w2, input int b, input int x1,
                               input int x2, input int t, output int y, output int p,
                               output int e);
    int acc;
    acc = b + ((w1 * x1) >>> 4) + ((w2 * x2) >>> 4);
    y = (acc > 8191) ? 8191 : ((acc < -8192) ? -8192 : acc);
    p = (acc >= 0) ? 1 : 3;
    e = ((acc < 0) != (t[1] == 1'b1)) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_w1 = 0; m_w2 = 0; m_b = 0; m_sc = 0; m_ec = 0;
      m_busy = 0; m_rv = 0; m_age = 0;
    end else begin
      if (!m_busy) begin
        if (bus.sample_valid) begin
          eval(m_w1, m_w2, m_b, int'($signed(bus.sample[15:9])),
               int'($signed(bus.sample[8:2])), int'(bus.sample[1:0]), m_y, m_p, m_e);
          m_busy = 1;
          m_age = 1;
        end
        if (ld_w) begin
          m_w1 = int'(w1_in); m_w2 = int'(w2_in); m_b = int'(b_in);
        end
      end else if (m_age < 3) begin
        m_age++;
        if (m_age == 3) m_rv = 1;
      end else if (bus.result_ready) begin
        m_busy = 0;
        m_rv = 0;
        m_age = 0;
        if (!clr_stats) begin
          if (m_sc < MAXC) m_sc++;
          if (m_e == 1 && m_ec < MAXC) m_ec++;
        end
      end
      if (clr_stats) begin
        m_sc = 0; m_ec = 0;
      end
    end
  end

  // ---------------- literal expectations posted by stimulus ----------------
  string lit_name[$];
  int    lit_act[$];
  int    lit_exp[$];
  bit    chk_en = 1'b0;
  bit    done = 1'b0;

  task automatic post(input string n, input int a, input int e);
    lit_name.push_back(n);
    lit_act.push_back(a);
    lit_exp.push_back(e);
  endtask

  // ---------------- compare process ----------------
  int n_cmp = 0;
  int n_fail = 0;
  int rd = 0;

  task automatic chk(input string n, input int a, input int e);
    n_cmp++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("result_valid", int'(bus.result_valid), int'(m_rv));
      chk("sample_ready", int'(bus.sample_ready), int'(!m_busy));
      chk("sample_cnt", int'(sample_cnt), m_sc);
      chk("err_cnt", int'(err_cnt), m_ec);
      if (m_rv) begin
        chk("y_out", int'(bus.y_out), m_y);
        chk("pred", int'(bus.pred), m_p);
        chk("err", int'(bus.err), m_e);
      end
    end
    while (rd < lit_name.size()) begin
      chk(lit_name[rd], lit_act[rd], lit_exp[rd]);
      rd++;
    end
    if (done && rd == lit_name.size()) begin
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int w1, input int w2, input int b);
    w1_in = 14'(w1); w2_in = 14'(w2); b_in = 14'(b);
    ld_w = 1'b1;
    step();
    ld_w = 1'b0;
  endtask

  // ld_mode: 0 none, 1 on the accept edge, 2 throughout the result hold.
  task automatic do_sample(input int x1, input int x2, input logic [1:0] t, input int hold,
                           input bit clr, input int ld_mode, input int nw1, input int nw2,
                           input int nb, output int y, output int p, output int e,
                           output int lat);
    bus.sample = {7'(x1), 7'(x2), t};
    bus.sample_valid = 1'b1;
    if (ld_mode == 1) begin
      w1_in = 14'(nw1); w2_in = 14'(nw2); b_in = 14'(nb);
      ld_w = 1'b1;
    end
    step();
    bus.sample_valid = 1'b0;
    ld_w = 1'b0;
    lat = 0;
    while (!bus.result_valid && lat < 10) begin
      step();
      lat++;
    end
    if (!bus.result_valid) post("result_timeout", 0, 1);
    y = int'(bus.y_out);
    p = int'(bus.pred);
    e = int'(bus.err);
    if (ld_mode == 2) begin
      w1_in = 14'(nw1); w2_in = 14'(nw2); b_in = 14'(nb);
      ld_w = 1'b1;
    end
    repeat (hold) step();
    ld_w = 1'b0;
    bus.result_ready = 1'b1;
    clr_stats = clr;
    step();
    bus.result_ready = 1'b0;
    clr_stats = 1'b0;
  endtask

  initial begin
    int y, p, e, lat;
    bus.sample_valid = 1'b0;
    bus.sample = '0;
    bus.result_ready = 1'b0;
    rst = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    post("rst_result_valid", int'(bus.result_valid), 0);
    post("rst_sample_ready", int'(bus.sample_ready), 1);
    post("rst_pred", int'(bus.pred), 1);
    post("rst_y_out", int'(bus.y_out), 0);
    post("rst_sample_cnt", int'(sample_cnt), 0);

    // Basic
    load(256, -128, 64);
    do_sample(24, 16, 2'b01, 0, 0, 0, 0, 0, 0, y, p, e, lat);
    post("basic_latency", lat, 2);
    post("basic_y", y, 320);
    post("basic_pred", p, 1);
    post("basic_err", e, 0);
    post("basic_sample_cnt", int'(sample_cnt), 1);
    post("basic_err_cnt", int'(err_cnt), 0);

    // Negative / misclassified
    do_sample(-32, 32, 2'b01, 0, 0, 0, 0, 0, 0, y, p, e, lat);
    post("neg_y", y, -704);
    post("neg_pred", p, 3);
    post("neg_err", e, 1);
    post("neg_err_cnt", int'(err_cnt), 1);

    // Saturation
    load(8191, 8191, 8191);
    do_sample(63, 63, 2'b01, 0, 0, 0, 0, 0, 0, y, p, e, lat);
    post("sat_pos_y", y, 8191);
    post("sat_pos_pred", p, 1);
    load(-8192, -8192, -8192);
    do_sample(63, 63, 2'b01, 0, 0, 0, 0, 0, 0, y, p, e, lat);
    post("sat_neg_y", y, -8192);
    post("sat_neg_pred", p, 3);
    load(0, 0, 0);
    do_sample(0, 0, 2'b01, 0, 0, 0, 0, 0, 0, y, p, e, lat);
    post("zero_y", y, 0);
    post("zero_pred", p, 1);

    // Floor shift: 3*-5 = -15 -> -1
    load(3, 0, 0);
    do_sample(-5, 0, 2'b11, 0, 0, 0, 0, 0, 0, y, p, e, lat);
    post("floor_y", y, -1);
    post("floor_pred", p, 3);
    post("floor_err", e, 0);

    // Backpressure with ld_w held during RESP (must be ignored)
    load(256, -128, 64);
    do_sample(24, 16, 2'b01, 5, 0, 2, 0, 0, 0, y, p, e, lat);
    post("bp_y", y, 320);
    do_sample(24, 16, 2'b01, 0, 0, 0, 0, 0, 0, y, p, e, lat);
    post("bp_weights_kept_y", y, 320);

    // ld_w on the accept edge: this sample uses old weights, next uses new
    do_sample(24, 16, 2'b01, 0, 0, 1, 0, 0, 0, y, p, e, lat);
    post("ldacc_old_y", y, 320);
    do_sample(24, 16, 2'b01, 0, 0, 0, 0, 0, 0, y, p, e, lat);
    post("ldacc_new_y", y, 0);

    // Saturating counters
    for (int i = 0; i < 300; i++) begin
      do_sample(0, 0, 2'b11, 0, 0, 0, 0, 0, 0, y, p, e, lat);
    end
    post("sat_sample_cnt", int'(sample_cnt), 255);
    post("sat_err_cnt", int'(err_cnt), 255);
    do_sample(0, 0, 2'b10, 0, 1, 0, 0, 0, 0, y, p, e, lat);
    post("clr_sample_cnt", int'(sample_cnt), 0);
    post("clr_err_cnt", int'(err_cnt), 0);

    // Reset during MUL2
    load(256, -128, 64);
    do_sample(24, 16, 2'b11, 0, 0, 0, 0, 0, 0, y, p, e, lat);
    post("pre_rst_sample_cnt", int'(sample_cnt), 1);
    bus.sample = {7'(24), 7'(16), 2'b01};
    bus.sample_valid = 1'b1;
    step();
    bus.sample_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    post("midrst_result_valid", int'(bus.result_valid), 0);
    post("midrst_sample_ready", int'(bus.sample_ready), 1);
    post("midrst_sample_cnt", int'(sample_cnt), 0);
    post("midrst_err_cnt", int'(err_cnt), 0);
    do_sample(24, 16, 2'b01, 0, 0, 0, 0, 0, 0, y, p, e, lat);
    post("post_rst_y", y, 0);
    post("post_rst_pred", p, 1);

    repeat (3) step();
    done = 1'b1;
  end

endmodule
